set_assoc_wb_cache: RTL and testbench
=====================================

// Module: set_assoc_wb_cache
// PURPOSE
//  Parametrised N-way set-associative write-back data cache; successor to the direct-mapped MMU cache.
//  Sits between the core load/store unit and the AXI block-transfer bridge on a single clock.
//  Blocking (one outstanding miss), write-allocate; invalid-first then round-robin victim select.
//  Adds a flush mode that writes back all dirty lines and invalidates the array.
// PARAMETERS
//  WORD_SIZE           4  bytes per word (fixed 4; data paths are 32 bit)
//  NUM_WORDS_IN_BLOCK  4  words per line (power of 2, >=2)
//  NUM_SETS            8  sets (power of 2, >=2)
//  NUM_WAYS            2  ways per set (power of 2, 1..8)
//  OFF_W/IDX_W/TAG_W      local: clog2(NUM_WORDS_IN_BLOCK*4), clog2(NUM_SETS), 32-IDX_W-OFF_W
// PORTS
//  mmu_clk       in   1       clock, all state on posedge
//  i_rst         in   1       asynchronous, active-high reset
//  req_valid     in   1       core request; held stable until req_ready
//  req_ready     out  1       high only in IDLE with flush not pending
//  req_we        in   1       1 store, 0 load
//  req_addr      in   32      byte address; bits[1:0] ignored
//  req_func3     in   3       000 sb, 001 sh, 010 sw (store); echoed for loads
//  req_wdata     in   32      store data, LSB-aligned
//  req_reg       in   5       destination register tag (loads)
//  rsp_valid     out  1       one-cycle pulse: load data valid
//  rsp_rdata     out  32      full word at addressed location
//  rsp_reg       out  5       echoed req_reg
//  rsp_func3     out  3       echoed req_func3
//  wr_done       out  1       one-cycle pulse: store committed
//  mem_rd_req    out  1       refill request, level, held until mem_rd_valid
//  mem_rd_addr   out  32      line-aligned refill address
//  mem_rd_data   in   32*NWB  refill line, word 0 in LSBs
//  mem_rd_valid  in   1       refill data valid, one cycle
//  mem_wr_req    out  1       write-back request, level, held until mem_wr_ack
//  mem_wr_addr   out  32      line-aligned victim address {tag,index,0}
//  mem_wr_data   out  32*NWB  victim line
//  mem_wr_ack    in   1       write-back accepted, one cycle
//  flush_req     in   1       pulse: request full flush
//  flush_done    out  1       one-cycle pulse when flush finished
// BEHAVIOUR
//  Reset: all valid/dirty/RR-pointers 0, data/tags 0, FSM IDLE; every output 0 except req_ready=1.
//  FSM: IDLE, WB, REFILL, FILL, FLUSH_SCAN, FLUSH_WB.
//  IDLE: accept on req_valid&req_ready; tag compare across all ways same cycle.
//   hit load  -> rsp_valid/rsp_rdata/rsp_reg/rsp_func3 next cycle (latency 1); stay IDLE.
//   hit store -> byte-enable merge (sb [7:0], sh [15:0], sw/other [31:0]) into word, set dirty; wr_done next cycle.
//   miss      -> latch addr/we/func3/wdata/reg; victim = lowest invalid way else RR pointer[set];
//                victim dirty ? WB : REFILL. req_ready drops the cycle after acceptance.
//  WB: mem_wr_req=1 with victim addr/data; on mem_wr_ack -> REFILL, clear victim dirty.
//  REFILL: mem_rd_req=1, mem_rd_addr={latched addr[31:OFF_W],0}; on mem_rd_valid -> FILL, capture line.
//  FILL (1 cycle): write line (store merged), tag, valid=1, dirty=we; advance RR pointer[set] mod NUM_WAYS
//   only if victim was chosen by RR; pulse rsp_valid (load, word from refill data) or wr_done; -> IDLE.
//  Miss latency with ack/valid returned next cycle: clean 3 cycles accept->response, dirty 5.
//  mem_rd_req and mem_wr_req never both high. rsp_valid and wr_done never both high.
//  flush_req latched sticky; taken only in IDLE after current miss completes; req_ready=0 while pending.
//  FLUSH_SCAN walks set/way 0..NUM_SETS*NUM_WAYS-1, one line per cycle; dirty valid line -> FLUSH_WB
//   (mem_wr_req until ack, clear dirty, return to scan); every line invalidated. After last line:
//   flush_done pulse, -> IDLE. Flush on clean/empty cache takes NUM_SETS*NUM_WAYS cycles.
//  Request coincident with flush_req in IDLE: request is accepted first, flush follows.
//  mem_rd_valid/mem_wr_ack outside REFILL/WB (FLUSH_WB for ack) ignored.
//  Reset mid-operation: abort immediately, all state to reset values; no response for in-flight request.
// TESTING
//  Cold load 0x0000_0040 (mem word=0xDEADBEEF) -> one mem_rd_req addr 0x40, rsp_valid rdata 0xDEADBEEF reg echoed.
//  Repeat load 0x40 -> rsp_valid exactly 1 cycle after accept, no mem_rd_req.
//  sb 0xAA to 0x41 on hit line holding 0x11223344 -> wr_done; load 0x40 returns 0x1122AA44.
//  Fill NUM_WAYS+1 lines to set 0 (0x000,0x080,0x100), first dirty -> mem_wr_req addr 0x000 precedes refill 0x100.
//  Two dirty lines then flush_req -> two mem_wr_req, flush_done once; next load to either misses.
//  Assert i_rst during REFILL -> req_ready=1, mem_rd_req=0 immediately; later load 0x40 misses.

Source files
------------

// File: rtl/set_assoc_wb_cache_if.sv
// Core load/store and memory-bridge signal bundle for set_assoc_wb_cache.
// The slave modport is the cache side; master is the core/bridge side.
interface set_assoc_wb_cache_if #(
  parameter int NUM_WORDS_IN_BLOCK = 4
);
  localparam int LINE_W = 32 * NUM_WORDS_IN_BLOCK;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [2:0]        req_func3;
  logic [31:0]       req_wdata;
  logic [4:0]        req_reg;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [4:0]        rsp_reg;
  logic [2:0]        rsp_func3;
  logic              wr_done;
  logic              mem_rd_req;
  logic [31:0]       mem_rd_addr;
  logic [LINE_W-1:0] mem_rd_data;
  logic              mem_rd_valid;
  logic              mem_wr_req;
  logic [31:0]       mem_wr_addr;
  logic [LINE_W-1:0] mem_wr_data;
  logic              mem_wr_ack;
  logic              flush_req;
  logic              flush_done;

  modport slave (
    input  req_valid, req_we, req_addr, req_func3, req_wdata, req_reg,
           mem_rd_data, mem_rd_valid, mem_wr_ack, flush_req,
    output req_ready, rsp_valid, rsp_rdata, rsp_reg, rsp_func3, wr_done,
           mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data, flush_done
  );

  modport master (
    output req_valid, req_we, req_addr, req_func3, req_wdata, req_reg,
           mem_rd_data, mem_rd_valid, mem_wr_ack, flush_req,
    input  req_ready, rsp_valid, rsp_rdata, rsp_reg, rsp_func3, wr_done,
           mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data, flush_done
  );
endinterface

// File: rtl/set_assoc_wb_cache.sv
// N-way set-associative write-back, write-allocate data cache with one outstanding miss,
// invalid-first / round-robin replacement and a full write-back-and-invalidate flush.
module set_assoc_wb_cache #(
  parameter int WORD_SIZE          = 4,
  parameter int NUM_WORDS_IN_BLOCK = 4,
  parameter int NUM_SETS           = 8,
  parameter int NUM_WAYS           = 2
) (
  input logic              mmu_clk,
  input logic              i_rst,
  set_assoc_wb_cache_if.slave bus
);
  localparam int BO_W   = $clog2(WORD_SIZE);
  localparam int WSEL_W = $clog2(NUM_WORDS_IN_BLOCK);
  localparam int OFF_W  = $clog2(NUM_WORDS_IN_BLOCK * 4);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int LINE_W = 32 * NUM_WORDS_IN_BLOCK;

  typedef enum logic [2:0] {IDLE, WB, REFILL, FILL, FLUSH_SCAN, FLUSH_WB} state_t;
  state_t state_q, state_d;

  logic [LINE_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [WAY_W-1:0]    rr_q    [NUM_SETS];

  logic [31:0]       addr_q, wdata_q, rsp_rdata_q;
  logic              we_q, vic_rr_q, flush_pend_q;
  logic              rsp_valid_q, wr_done_q, flush_done_q;
  logic [2:0]        f3_q, rsp_f3_q;
  logic [4:0]        reg_q, rsp_reg_q;
  logic [WAY_W-1:0]  vic_q, fw_q;
  logic [IDX_W-1:0]  fs_q;
  logic [LINE_W-1:0] line_q;

  logic [IDX_W-1:0]  r_idx, m_idx, wb_set;
  logic [TAG_W-1:0]  r_tag, m_tag;
  logic [WSEL_W-1:0] r_wsel, m_wsel;
  logic [WAY_W-1:0]  hit_way, inv_way, victim, wb_way;
  logic              hit, inv_found, accept, req_ready, scan_dirty, scan_last;
  logic              mem_rd_req, mem_wr_req;
  logic [31:0]       hit_word, hit_merged, fill_word;
  logic [LINE_W-1:0] fill_line;

  // Byte-lane store merge: sb/sh land in the lane chosen by the low address bits.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [2:0] f3, input logic [BO_W-1:0] bo);
    logic [31:0] m, d;
    case (f3)
      3'b000:  begin m = 32'h0000_00FF << {bo, 3'b000}; d = wd << {bo, 3'b000}; end
      3'b001:  begin m = 32'h0000_FFFF << {bo[1], 4'b0000}; d = wd << {bo[1], 4'b0000}; end
      default: begin m = 32'hFFFF_FFFF; d = wd; end
    endcase
    return (old & ~m) | (d & m);
  endfunction

  assign r_idx  = bus.req_addr[OFF_W +: IDX_W];
  assign r_tag  = bus.req_addr[31 -: TAG_W];
  assign r_wsel = bus.req_addr[BO_W +: WSEL_W];
  assign m_idx  = addr_q[OFF_W +: IDX_W];
  assign m_tag  = addr_q[31 -: TAG_W];
  assign m_wsel = addr_q[BO_W +: WSEL_W];

  assign req_ready = (state_q == IDLE) && !flush_pend_q;
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    hit = 1'b0; hit_way = '0; inv_found = 1'b0; inv_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[r_idx][w] && tag_q[r_idx][w] == r_tag) begin
        hit = 1'b1; hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[r_idx][w]) begin
        inv_found = 1'b1; inv_way = WAY_W'(w);
      end
    end
  end

  assign victim     = inv_found ? inv_way : rr_q[r_idx];
  assign hit_word   = data_q[r_idx][hit_way][{r_wsel, 5'b00000} +: 32];
  assign hit_merged = merge(hit_word, bus.req_wdata, bus.req_func3, bus.req_addr[BO_W-1:0]);
  assign fill_word  = merge(line_q[{m_wsel, 5'b00000} +: 32], wdata_q, f3_q, addr_q[BO_W-1:0]);

  always_comb begin
    fill_line = line_q;
    if (we_q) fill_line[{m_wsel, 5'b00000} +: 32] = fill_word;
  end

  assign scan_dirty = valid_q[fs_q][fw_q] && dirty_q[fs_q][fw_q];
  assign scan_last  = (fs_q == IDX_W'(NUM_SETS - 1)) && (fw_q == WAY_W'(NUM_WAYS - 1));
  assign wb_set     = (state_q == FLUSH_WB) ? fs_q : m_idx;
  assign wb_way     = (state_q == FLUSH_WB) ? fw_q : vic_q;

  always_comb begin
    state_d    = state_q;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && !hit)    state_d = dirty_q[r_idx][victim] ? WB : REFILL;
        else if (flush_pend_q) state_d = FLUSH_SCAN;
      end
      WB: begin
        mem_wr_req = 1'b1;
        if (bus.mem_wr_ack) state_d = REFILL;
      end
      REFILL: begin
        mem_rd_req = 1'b1;
        if (bus.mem_rd_valid) state_d = FILL;
      end
      FILL: state_d = IDLE;
      FLUSH_SCAN: begin
        if (scan_dirty)     state_d = FLUSH_WB;
        else if (scan_last) state_d = IDLE;
      end
      FLUSH_WB: begin
        mem_wr_req = 1'b1;
        if (bus.mem_wr_ack) state_d = FLUSH_SCAN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mmu_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q <= '0; wdata_q <= '0; we_q <= 1'b0; f3_q <= '0; reg_q <= '0;
      vic_q <= '0; vic_rr_q <= 1'b0; line_q <= '0;
      flush_pend_q <= 1'b0; fs_q <= '0; fw_q <= '0;
      rsp_valid_q <= 1'b0; rsp_rdata_q <= '0; rsp_reg_q <= '0; rsp_f3_q <= '0;
      wr_done_q <= 1'b0; flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= 1'b0;
      wr_done_q    <= 1'b0;
      flush_done_q <= 1'b0;
      // Pending flush is consumed on the IDLE cycle that launches the scan.
      flush_pend_q <= bus.flush_req | (flush_pend_q & (state_q != IDLE));
      if (accept) begin
        addr_q <= bus.req_addr; wdata_q <= bus.req_wdata; we_q <= bus.req_we;
        f3_q <= bus.req_func3; reg_q <= bus.req_reg;
        vic_q <= victim; vic_rr_q <= !inv_found;
        if (hit && bus.req_we) wr_done_q <= 1'b1;
        else if (hit) begin
          rsp_valid_q <= 1'b1; rsp_rdata_q <= hit_word;
          rsp_reg_q <= bus.req_reg; rsp_f3_q <= bus.req_func3;
        end
      end
      // Miss response is registered on refill arrival so it shows during FILL.
      if (state_q == REFILL && bus.mem_rd_valid) begin
        line_q <= bus.mem_rd_data;
        if (we_q) wr_done_q <= 1'b1;
        else begin
          rsp_valid_q <= 1'b1; rsp_rdata_q <= bus.mem_rd_data[{m_wsel, 5'b00000} +: 32];
          rsp_reg_q <= reg_q; rsp_f3_q <= f3_q;
        end
      end
      if (state_q == FLUSH_SCAN && !scan_dirty) begin
        if (fw_q == WAY_W'(NUM_WAYS - 1)) begin
          fw_q <= '0; fs_q <= fs_q + 1'b1;
        end else fw_q <= fw_q + 1'b1;
        if (scan_last) flush_done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge mmu_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0; dirty_q[s] <= '0; rr_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          data_q[s][w] <= '0; tag_q[s][w] <= '0;
        end
      end
    end else begin
      if (accept && hit && bus.req_we) begin
        data_q[r_idx][hit_way][{r_wsel, 5'b00000} +: 32] <= hit_merged;
        dirty_q[r_idx][hit_way] <= 1'b1;
      end
      if (state_q == WB && bus.mem_wr_ack) dirty_q[m_idx][vic_q] <= 1'b0;
      if (state_q == FILL) begin
        data_q[m_idx][vic_q]  <= fill_line;
        tag_q[m_idx][vic_q]   <= m_tag;
        valid_q[m_idx][vic_q] <= 1'b1;
        dirty_q[m_idx][vic_q] <= we_q;
        if (vic_rr_q)
          rr_q[m_idx] <= (rr_q[m_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[m_idx] + 1'b1;
      end
      if (state_q == FLUSH_SCAN) valid_q[fs_q][fw_q] <= 1'b0;
      if (state_q == FLUSH_WB && bus.mem_wr_ack) dirty_q[fs_q][fw_q] <= 1'b0;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_reg     = rsp_reg_q;
  assign bus.rsp_func3   = rsp_f3_q;
  assign bus.wr_done     = wr_done_q;
  assign bus.flush_done  = flush_done_q;
  assign bus.mem_rd_req  = mem_rd_req;
  assign bus.mem_rd_addr = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
  assign bus.mem_wr_req  = mem_wr_req;
  assign bus.mem_wr_addr = {tag_q[wb_set][wb_way], wb_set, {OFF_W{1'b0}}};
  assign bus.mem_wr_data = data_q[wb_set][wb_way];
endmodule

// File: tb/tb_set_assoc_wb_cache.sv
// Directed bench for set_assoc_wb_cache with a one-cycle-delay memory bridge model.
module tb_set_assoc_wb_cache;
  localparam int NWB = 4;

  logic clk, rst;
  int   n_chk, n_pass, n_fail;
  logic [31:0] mem [logic [31:0]];
  logic [32:0] ev_log [$];   // {is_write, line address}
  logic rd_seen, wr_seen;

  set_assoc_wb_cache_if #(.NUM_WORDS_IN_BLOCK(NWB)) bif ();

  set_assoc_wb_cache #(.WORD_SIZE(4), .NUM_WORDS_IN_BLOCK(NWB), .NUM_SETS(8), .NUM_WAYS(2))
    dut (.mmu_clk(clk), .i_rst(rst), .bus(bif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bridge model: answers a level request one cycle after first seeing it.
  initial begin
    bif.mem_rd_valid = 1'b0; bif.mem_wr_ack = 1'b0; bif.mem_rd_data = '0;
    rd_seen = 1'b0; wr_seen = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        rd_seen = 1'b0; wr_seen = 1'b0; bif.mem_rd_valid = 1'b0; bif.mem_wr_ack = 1'b0;
      end else begin
        if (bif.mem_rd_valid) begin
          bif.mem_rd_valid = 1'b0; rd_seen = 1'b0;
        end else if (bif.mem_rd_req) begin
          if (rd_seen) begin
            for (int i = 0; i < NWB; i++) bif.mem_rd_data[i*32 +: 32] = memrd(bif.mem_rd_addr + 32'(4*i));
            bif.mem_rd_valid = 1'b1;
            ev_log.push_back({1'b0, bif.mem_rd_addr});
          end else rd_seen = 1'b1;
        end
        if (bif.mem_wr_ack) begin
          bif.mem_wr_ack = 1'b0; wr_seen = 1'b0;
        end else if (bif.mem_wr_req) begin
          if (wr_seen) begin
            for (int i = 0; i < NWB; i++) mem[bif.mem_wr_addr + 32'(4*i)] = bif.mem_wr_data[i*32 +: 32];
            bif.mem_wr_ack = 1'b1;
            ev_log.push_back({1'b1, bif.mem_wr_addr});
          end else wr_seen = 1'b1;
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, input logic [4:0] rg);
    int n;
    n = 0;
    bif.req_valid = 1'b1; bif.req_we = we; bif.req_addr = a;
    bif.req_func3 = f3; bif.req_wdata = wd; bif.req_reg = rg;
    while (!bif.req_ready && n < 200) begin tick(); n++; end
    chk("req_accept", {31'b0, bif.req_ready}, 32'd1);
    tick();
    bif.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!(bif.rsp_valid || bif.wr_done) && lat < 60) begin tick(); lat++; end
  endtask

  task automatic ld(input string nm, input logic [31:0] a, input logic [4:0] rg,
                    input logic [2:0] f3, input logic [31:0] exp_d, input int exp_lat);
    int lat;
    issue(1'b0, a, f3, 32'h0, rg);
    wait_rsp(lat);
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_rspv"}, {31'b0, bif.rsp_valid}, 32'd1);
    chk({nm, "_data"}, bif.rsp_rdata, exp_d);
    chk({nm, "_reg"}, {27'b0, bif.rsp_reg}, {27'b0, rg});
    chk({nm, "_f3"}, {29'b0, bif.rsp_func3}, {29'b0, f3});
  endtask

  task automatic st(input string nm, input logic [31:0] a, input logic [2:0] f3,
                    input logic [31:0] wd, input int exp_lat);
    int lat;
    issue(1'b1, a, f3, wd, 5'd0);
    wait_rsp(lat);
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_wrdone"}, {31'b0, bif.wr_done}, 32'd1);
    chk({nm, "_norsp"}, {31'b0, bif.rsp_valid}, 32'd0);
  endtask

  initial begin
    int lat, n, base;
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1;
    bif.req_valid = 1'b0; bif.req_we = 1'b0; bif.req_addr = '0; bif.req_func3 = '0;
    bif.req_wdata = '0; bif.req_reg = '0; bif.flush_req = 1'b0;
    mem[32'h40] = 32'hDEAD_BEEF;
    repeat (2) tick();
    chk("rst_ready", {31'b0, bif.req_ready}, 32'd1);
    chk("rst_rspv", {31'b0, bif.rsp_valid}, 32'd0);
    chk("rst_wrdone", {31'b0, bif.wr_done}, 32'd0);
    chk("rst_rdreq", {31'b0, bif.mem_rd_req}, 32'd0);
    chk("rst_wrreq", {31'b0, bif.mem_wr_req}, 32'd0);
    chk("rst_fdone", {31'b0, bif.flush_done}, 32'd0);
    chk("rst_rdaddr", bif.mem_rd_addr, 32'h0);
    chk("rst_wraddr", bif.mem_wr_addr, 32'h0);
    rst = 1'b0;
    tick();

    // Cold load: one refill of line 0x40, response 3 cycles after accept.
    issue(1'b0, 32'h40, 3'b010, 32'h0, 5'd5);
    chk("cold_ready_drop", {31'b0, bif.req_ready}, 32'd0);
    wait_rsp(lat);
    chk("cold_lat", 32'(lat), 32'd3);
    chk("cold_data", bif.rsp_rdata, 32'hDEAD_BEEF);
    chk("cold_reg", {27'b0, bif.rsp_reg}, 32'd5);
    chk("cold_nrd", 32'(ev_log.size()), 32'd1);
    chk("cold_rdaddr", ev_log[0][31:0], 32'h40);

    ld("hit_ld", 32'h40, 5'd7, 3'b100, 32'hDEAD_BEEF, 1);
    tick();
    chk("hit_pulse", {31'b0, bif.rsp_valid}, 32'd0);
    chk("hit_nrd", 32'(ev_log.size()), 32'd1);

    st("sw_hit", 32'h40, 3'b010, 32'h1122_3344, 1);
    st("sb_hit", 32'h41, 3'b000, 32'h0000_00AA, 1);
    ld("ld_sb", 32'h40, 5'd1, 3'b010, 32'h1122_AA44, 1);
    st("sh_hit", 32'h42, 3'b001, 32'h0000_BEEF, 1);
    ld("ld_sh", 32'h40, 5'd2, 3'b010, 32'hBEEF_AA44, 1);

    // Set 0: dirty way 0, clean way 1, third line evicts way 0 via write-back.
    st("st_miss", 32'h000, 3'b010, 32'hCAFE_0001, 3);
    ld("ld_080", 32'h080, 5'd3, 3'b010, 32'hC0DE_0080, 3);
    ld("ld_100", 32'h100, 5'd4, 3'b010, 32'hC0DE_0100, 5);
    n = ev_log.size();
    chk("evict_wr", {31'b0, ev_log[n-2][32]}, 32'd1);
    chk("evict_wraddr", ev_log[n-2][31:0], 32'h000);
    chk("evict_rd", {31'b0, ev_log[n-1][32]}, 32'd0);
    chk("evict_rdaddr", ev_log[n-1][31:0], 32'h100);
    ld("ld_000_back", 32'h000, 5'd6, 3'b010, 32'hCAFE_0001, 3);
    st("sw_000", 32'h000, 3'b010, 32'h1234_5678, 1);

    // Flush with two dirty lines: 0x000 (set 0) then 0x040 (set 4).
    base = ev_log.size();
    bif.flush_req = 1'b1;
    tick();
    bif.flush_req = 1'b0;
    chk("flush_pend_ready", {31'b0, bif.req_ready}, 32'd0);
    n = 0;
    while (!bif.flush_done && n < 400) begin tick(); n++; end
    chk("flush1_done", {31'b0, bif.flush_done}, 32'd1);
    chk("flush1_nwb", 32'(ev_log.size() - base), 32'd2);
    chk("flush1_wb0", ev_log[base][31:0], 32'h000);
    chk("flush1_wb1", ev_log[base+1][31:0], 32'h040);
    tick();
    chk("flush1_pulse", {31'b0, bif.flush_done}, 32'd0);
    chk("flush1_ready", {31'b0, bif.req_ready}, 32'd1);
    ld("post_flush_40", 32'h40, 5'd8, 3'b010, 32'hBEEF_AA44, 3);
    ld("post_flush_00", 32'h000, 5'd9, 3'b010, 32'h1234_5678, 3);

    // Clean cache: pend cycle plus one cycle per line, no write-backs.
    base = ev_log.size();
    bif.flush_req = 1'b1;
    tick();
    bif.flush_req = 1'b0;
    n = 0;
    while (!bif.flush_done && n < 400) begin tick(); n++; end
    chk("flush2_cycles", 32'(n), 32'd17);
    chk("flush2_nwb", 32'(ev_log.size() - base), 32'd0);
    tick();

    // Reset while a refill is outstanding.
    issue(1'b0, 32'h0C0, 3'b010, 32'h0, 5'd3);
    chk("pre_rst_rdreq", {31'b0, bif.mem_rd_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'b0, bif.req_ready}, 32'd1);
    chk("midrst_rdreq", {31'b0, bif.mem_rd_req}, 32'd0);
    repeat (3) tick();
    chk("midrst_norsp", {31'b0, bif.rsp_valid}, 32'd0);
    rst = 1'b0;
    tick();
    chk("postrst_norsp", {31'b0, bif.rsp_valid}, 32'd0);
    ld("postrst_40", 32'h40, 5'd10, 3'b010, 32'hBEEF_AA44, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
